// File: rtl/hfosc_trim_ctrl_if.sv
// hfosc_trim_ctrl_if: register-port bus between the trim sequencer and the calibration block
interface hfosc_trim_ctrl_if;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_cyc;
  logic        m_we;
  logic        m_ack;
  modport master(output m_addr, m_wdata, m_cyc, m_we, input m_rdata, m_ack);
  modport slave(input m_addr, m_wdata, m_cyc, m_we, output m_rdata, m_ack);
endinterface

// File: rtl/hfosc_trim_ctrl.sv
// hfosc_trim_ctrl: successive-approximation HF oscillator trim sequencer with verification measurement
module hfosc_trim_ctrl #(
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [30:0]         target,
  input  logic [23:0]         meas_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [9:0]          trim_out,
  output logic [30:0]         cnt_out,
  hfosc_trim_ctrl_if.master   m
);
  typedef enum logic [3:0] {
    IDLE, SET_TRIM, START, POLL, EVAL, VERIFY_SET, VERIFY_START, VERIFY_POLL, FIN
  } state_t;
  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, fail_q, fail_d;
  logic [9:0]  trim_out_q, trim_out_d, trim_q, trim_d, wtrim_q, wtrim_d;
  logic [30:0] cnt_out_q, cnt_out_d, count_q, count_d, target_q, target_d;
  logic [23:0] meas_q, meas_d;
  logic [3:0]  bit_q, bit_d, m_addr_q, m_addr_d;
  logic [15:0] poll_q, poll_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        m_cyc_q, m_cyc_d, m_we_q, m_we_d;
  logic        bus_st, is_trim, is_poll, is_start, ack, valid, timeout, req_we;
  logic [9:0]  trial;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  assign ack       = m_cyc_q && m.m_ack;
  assign valid     = m.m_rdata[31];
  assign timeout   = poll_q == POLL_MAX - 16'd1;
  assign is_trim   = state_q inside {SET_TRIM, VERIFY_SET};
  assign is_start  = state_q inside {START, VERIFY_START};
  assign is_poll   = state_q inside {POLL, VERIFY_POLL};
  assign bus_st    = is_trim || is_start || is_poll;
  assign trial     = state_q == SET_TRIM ? trim_q | (10'd1 << bit_q) : trim_q;
  assign req_we    = !is_poll;
  assign req_addr  = is_trim ? 4'hB : 4'h9;
  assign req_wdata = is_trim ? {22'd0, trial} : is_start ? {8'h00, meas_q} : 32'd0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign trim_out  = trim_out_q;
  assign cnt_out   = cnt_out_q;
  assign m.m_cyc   = m_cyc_q;
  assign m.m_we    = m_we_q;
  assign m.m_addr  = m_addr_q;
  assign m.m_wdata = m_wdata_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fail_q     <= 1'b0;
      trim_out_q <= '0;
      trim_q     <= '0;
      wtrim_q    <= '0;
      cnt_out_q  <= '0;
      count_q    <= '0;
      target_q   <= '0;
      meas_q     <= '0;
      bit_q      <= '0;
      poll_q     <= '0;
      m_cyc_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      trim_out_q <= trim_out_d;
      trim_q     <= trim_d;
      wtrim_q    <= wtrim_d;
      cnt_out_q  <= cnt_out_d;
      count_q    <= count_d;
      target_q   <= target_d;
      meas_q     <= meas_d;
      bit_q      <= bit_d;
      poll_q     <= poll_d;
      m_cyc_q    <= m_cyc_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = start ? SET_TRIM : IDLE;
      SET_TRIM:     state_d = ack ? START : SET_TRIM;
      START:        state_d = ack ? POLL : START;
      POLL:         state_d = !ack ? POLL : valid ? EVAL : timeout ? FIN : POLL;
      EVAL:         state_d = bit_q == 4'd0 ? VERIFY_SET : SET_TRIM;
      VERIFY_SET:   state_d = ack ? VERIFY_START : VERIFY_SET;
      VERIFY_START: state_d = ack ? VERIFY_POLL : VERIFY_START;
      VERIFY_POLL:  state_d = !ack ? VERIFY_POLL : (valid || timeout) ? FIN : VERIFY_POLL;
      FIN:          state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    fail_d     = fail_q;
    trim_out_d = trim_out_q;
    trim_d     = trim_q;
    wtrim_d    = wtrim_q;
    cnt_out_d  = cnt_out_q;
    count_d    = count_q;
    target_d   = target_q;
    meas_d     = meas_q;
    bit_d      = bit_q;
    poll_d     = poll_q;
    m_cyc_d    = bus_st && !ack;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if (bus_st && !m_cyc_q) begin
      m_we_d    = req_we;
      m_addr_d  = req_addr;
      m_wdata_d = req_wdata;
      wtrim_d   = is_trim ? trial : wtrim_q;
    end
    if (ack && is_start) poll_d = '0;
    if (ack && is_poll) begin
      count_d = m.m_rdata[30:0];
      poll_d  = poll_q + 16'd1;
      fail_d  = fail_q || (!valid && timeout);
      cnt_out_d = (state_q == VERIFY_POLL && valid) ? m.m_rdata[30:0] : cnt_out_q;
    end
    if (state_q == EVAL) begin
      trim_d = count_q <= target_q ? trial | (10'd1 << bit_q) : trim_q;
      bit_d  = bit_q == 4'd0 ? bit_q : bit_q - 4'd1;
    end
    if (state_q == IDLE && start) begin
      target_d = target;
      meas_d   = meas_len;
      trim_d   = '0;
      bit_d    = 4'd9;
      err_d    = 1'b0;
      fail_d   = 1'b0;
      busy_d   = 1'b1;
    end
    if (state_q == FIN) begin
      trim_out_d = wtrim_q;
      done_d     = !fail_q;
      err_d      = fail_q;
      busy_d     = 1'b0;
    end
  end
endmodule

// File: tb/tb_hfosc_trim_ctrl.sv
// tb_hfosc_trim_ctrl: randomized scoreboard bench with a slave model count = 2*trim+100
module tb_hfosc_trim_ctrl;
  typedef struct {
    logic [9:0]  trim;
    logic [30:0] cnt;
    bit          err;
    int          n;
    int          tr[11];
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [30:0] target = '0;
  logic [23:0] meas_len = '0;
  logic        busy, done, err;
  logic [9:0]  trim_out;
  logic [30:0] cnt_out;
  int          total = 0;
  int          bad = 0;
  int          delay = 1;
  bit          never = 0;
  logic [9:0]  s_trim = '0;
  int          s_polls = 0;
  logic        ack_r = 0;
  int          wcnt = 0;
  int          wlog[$];
  exp_t        sq[$];
  exp_t        me;
  bit          busy_prev = 0, done_prev = 0, pend = 0, ack_prev = 0;
  logic [36:0] snap = '0;
  hfosc_trim_ctrl_if bus();
  hfosc_trim_ctrl #(.POLL_MAX(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .meas_len(meas_len),
    .busy(busy), .done(done), .err(err), .trim_out(trim_out), .cnt_out(cnt_out),
    .m(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input longint tgt);
    exp_t e;
    int best = 0;
    for (int t = 0; t < 1024; t++) if (2 * t + 100 <= tgt) best = t;
    e.trim = 10'(best);
    e.cnt = 31'(2 * best + 100);
    e.err = 0;
    e.n = 11;
    for (int b = 9; b >= 0; b--) e.tr[9 - b] = (best & ~((1 << (b + 1)) - 1)) | (1 << b);
    e.tr[10] = best;
    return e;
  endfunction
  assign bus.m_ack = ack_r;
  assign bus.m_rdata = {!never && s_polls >= 5, 31'(2 * int'(s_trim) + 100)};
  always @(posedge clk) begin
    if (!bus.m_cyc || ack_r) begin
      wcnt <= 0;
      ack_r <= 0;
    end else begin
      wcnt <= wcnt + 1;
      ack_r <= wcnt + 1 >= delay;
    end
    if (bus.m_cyc && bus.m_ack) begin
      if (bus.m_we && bus.m_addr == 4'hB) begin
        s_trim <= bus.m_wdata[9:0];
        wlog.push_back(int'(bus.m_wdata[9:0]));
      end
      if (bus.m_we && bus.m_addr == 4'h9) begin
        s_polls <= 0;
        chk("meas_wdata", bus.m_wdata, {8'h00, meas_len});
      end
      if (!bus.m_we && bus.m_addr == 4'h9) s_polls <= s_polls + 1;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_cyc && pend) chk("bus_stable", {bus.m_we, bus.m_addr, bus.m_wdata}, snap);
      if (ack_prev) chk("cyc_gap_after_ack", bus.m_cyc, 0);
      pend <= bus.m_cyc && !bus.m_ack;
      ack_prev <= bus.m_cyc && bus.m_ack;
    end else begin
      pend <= 0;
      ack_prev <= 0;
    end
    snap <= {bus.m_we, bus.m_addr, bus.m_wdata};
  end
  always @(negedge clk) begin
    if (rst_n && done_prev) chk("done_one_cycle", done, 0);
    if (rst_n && busy_prev && !busy) begin
      chk("pending_runs", sq.size() > 0, 1);
      if (sq.size() > 0) begin
        me = sq.pop_front();
        chk("trim_out", trim_out, me.trim);
        chk("err", err, me.err);
        chk("done", done, !me.err);
        if (!me.err) chk("cnt_out", cnt_out, me.cnt);
        else chk("polls_before_timeout", s_polls, 8);
        chk("n_trim_writes", wlog.size(), me.n);
        for (int i = 0; i < me.n && i < wlog.size(); i++) chk($sformatf("trial%0d", i), wlog[i], me.tr[i]);
      end
      wlog.delete();
    end
    busy_prev <= busy;
    done_prev <= done;
  end
  task automatic run(input longint tgt, input int dly, input bit nev);
    exp_t e;
    int n = 0;
    if (nev) begin
      e.trim = 10'd512;
      e.cnt = '0;
      e.err = 1;
      e.n = 1;
      e.tr[0] = 512;
    end else e = model(tgt);
    delay = dly;
    never = nev;
    sq.push_back(e);
    @(negedge clk);
    target = 31'(tgt);
    meas_len = 24'($urandom);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_rise", busy, 1);
    repeat ($urandom_range(2, 20)) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("run_finished_in_budget", busy, 0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int c;
    int n;
    repeat (3) @(negedge clk);
    chk("reset_status", {busy, done, err, trim_out, cnt_out}, 0);
    chk("reset_bus", {bus.m_cyc, bus.m_we, bus.m_addr, bus.m_wdata}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run(900, 1, 0);
    run(50, 1, 0);
    run(31'h7FFFFFFF, 1, 0);
    run(900, 4, 0);
    run(900, 1, 1);
    c = 0;
    repeat (30) begin
      @(negedge clk);
      c += int'(bus.m_cyc);
    end
    chk("idle_after_err", c, 0);
    chk("err_sticky", err, 1);
    target = 31'd900;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(bus.m_cyc && !bus.m_we) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_poll", bus.m_cyc && !bus.m_we, 1);
    rst_n = 0;
    @(negedge clk);
    chk("rst_cyc_low", bus.m_cyc, 0);
    chk("rst_busy_low", busy, 0);
    @(negedge clk);
    rst_n = 1;
    wlog.delete();
    repeat (2) @(negedge clk);
    run(900, 1, 0);
    for (int i = 0; i < 12; i++) run($urandom_range(0, 2400), $urandom_range(1, 4), 0);
    chk("all_runs_retired", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
